// File: rtl/foc_sched_pkg.sv
// Shared state encoding and counter widths for the FOC loop scheduler.
package foc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POS_RUN = 3'd1,
    SPD_RUN = 3'd2,
    CUR_RUN = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int CNT_W = 8;
  localparam int TMR_W = 16;

endpackage

// File: rtl/foc_tick_divider.sv
// Modulo-DIV counter of accepted PWM ticks; oSlot marks the tick on which the loop runs.
module foc_tick_divider
  import foc_sched_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClr,
  input  logic iAdv,
  output logic oSlot
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iClr) begin
      cnt_d = '0;
    end else if (iAdv) begin
      cnt_d = (cnt_q == CNT_W'(DIV - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oSlot = (cnt_q == '0);

endmodule

// File: rtl/foc_loop_scheduler.sv
// Sequences position -> speed -> current PI loops once per PWM tick, flagging overruns/timeouts.
// Optional macro FOC_SCHED_STATS_EN adds a saturating dropped-tick counter output oOverrun_cnt.
module foc_loop_scheduler
  import foc_sched_pkg::*;
#(
  parameter int POS_DIV = 16,
  parameter int SPD_DIV = 4,
  parameter int TIMEOUT = 255
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iPwm_tick,
  input  logic iEnable,
  input  logic iClr_err,
  output logic oPos_en,
  input  logic iPos_done,
  output logic oSpd_en,
  input  logic iSpd_done,
  output logic oCur_en,
  input  logic iCur_done,
  output logic oBusy,
  output logic oCycle_done,
  output logic oOverrun,
  output logic oTimeout
`ifdef FOC_SCHED_STATS_EN
  ,
  output logic [15:0] oOverrun_cnt
`endif
);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             spdSched_q;
  logic             posEn_q, spdEn_q, curEn_q, busy_q, cycleDone_q;
  logic             overrun_q, timeout_q;
  logic             posSlot, spdSlot, tickAccept, overrunEvt;
  logic             stageDone, timerHit, timeoutEvt;

  assign tickAccept = iPwm_tick & iEnable & (state_q == IDLE);
  assign overrunEvt = iPwm_tick & (state_q != IDLE);
  assign timerHit   = (timer_q == TMR_W'(TIMEOUT - 1));

  foc_tick_divider #(.DIV(POS_DIV)) uPosDiv (
    .iClk(iClk), .iRst_n(iRst_n), .iClr(~iEnable), .iAdv(tickAccept), .oSlot(posSlot)
  );

  foc_tick_divider #(.DIV(SPD_DIV)) uSpdDiv (
    .iClk(iClk), .iRst_n(iRst_n), .iClr(~iEnable), .iAdv(tickAccept), .oSlot(spdSlot)
  );

  // Done only counts while the stage's own enable is high.
  always_comb begin
    stageDone = 1'b0;
    unique case (state_q)
      POS_RUN: stageDone = iPos_done & posEn_q;
      SPD_RUN: stageDone = iSpd_done & spdEn_q;
      CUR_RUN: stageDone = iCur_done & curEn_q;
      default: stageDone = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    timeoutEvt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tickAccept) begin
          if (posSlot)      state_d = POS_RUN;
          else if (spdSlot) state_d = SPD_RUN;
          else              state_d = CUR_RUN;
        end
      end
      POS_RUN, SPD_RUN, CUR_RUN: begin
        if (stageDone || timerHit) begin
          timeoutEvt = ~stageDone;
          if (state_q == POS_RUN)      state_d = spdSched_q ? SPD_RUN : CUR_RUN;
          else if (state_q == SPD_RUN) state_d = CUR_RUN;
          else                         state_d = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!iEnable) begin
      state_d = IDLE;
      timer_d = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      spdSched_q  <= 1'b0;
      posEn_q     <= 1'b0;
      spdEn_q     <= 1'b0;
      curEn_q     <= 1'b0;
      busy_q      <= 1'b0;
      cycleDone_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      if (tickAccept) spdSched_q <= spdSlot;
      posEn_q     <= (state_d == POS_RUN);
      spdEn_q     <= (state_d == SPD_RUN);
      curEn_q     <= (state_d == CUR_RUN);
      busy_q      <= (state_d != IDLE);
      cycleDone_q <= (state_d == DONE);
      overrun_q   <= overrunEvt | (overrun_q & ~iClr_err);
      timeout_q   <= timeoutEvt | (timeout_q & ~iClr_err);
    end
  end

`ifdef FOC_SCHED_STATS_EN
  logic [15:0] ovrCnt_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ovrCnt_q <= '0;
    end else if (iClr_err) begin
      ovrCnt_q <= {15'd0, overrunEvt};
    end else if (overrunEvt && ovrCnt_q != 16'hFFFF) begin
      ovrCnt_q <= ovrCnt_q + 16'd1;
    end
  end

  assign oOverrun_cnt = ovrCnt_q;
`endif

  assign oPos_en     = posEn_q;
  assign oSpd_en     = spdEn_q;
  assign oCur_en     = curEn_q;
  assign oBusy       = busy_q;
  assign oCycle_done = cycleDone_q;
  assign oOverrun    = overrun_q;
  assign oTimeout    = timeout_q;

endmodule

// File: tb/tb_foc_loop_scheduler.sv
// Scoreboard bench for foc_loop_scheduler: expected stage-start order queued per tick, compared to observed.
module tb_foc_loop_scheduler;

  localparam int POS_DIV = 4;
  localparam int SPD_DIV = 2;
  localparam int TIMEOUT = 20;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  logic iPwm_tick = 1'b0;
  logic iEnable = 1'b0;
  logic iClr_err = 1'b0;
  logic iPos_done = 1'b0;
  logic iSpd_done = 1'b0;
  logic iCur_done = 1'b0;
  logic oPos_en, oSpd_en, oCur_en, oBusy, oCycle_done, oOverrun, oTimeout;
`ifdef FOC_SCHED_STATS_EN
  logic [15:0] oOverrun_cnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int expQ[$];
  int obsQ[$];
  int modelPos = 0;
  int modelSpd = 0;
  int doneCnt = 0;
  int respPos = 0, respSpd = 0, respCur = 0;
  bit spdHang = 1'b0;
  bit prevPos = 1'b0, prevSpd = 1'b0, prevCur = 1'b0;

  foc_loop_scheduler #(.POS_DIV(POS_DIV), .SPD_DIV(SPD_DIV), .TIMEOUT(TIMEOUT)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iPwm_tick(iPwm_tick), .iEnable(iEnable),
    .iClr_err(iClr_err), .oPos_en(oPos_en), .iPos_done(iPos_done),
    .oSpd_en(oSpd_en), .iSpd_done(iSpd_done), .oCur_en(oCur_en),
    .iCur_done(iCur_done), .oBusy(oBusy), .oCycle_done(oCycle_done),
    .oOverrun(oOverrun), .oTimeout(oTimeout)
`ifdef FOC_SCHED_STATS_EN
    , .oOverrun_cnt(oOverrun_cnt)
`endif
  );

  always #5 iClk = ~iClk;

  // Loop models: done goes high on the 4th negedge that sees en high (3 cycles after rise).
  initial begin
    forever begin
      @(negedge iClk);
      respPos = oPos_en ? respPos + 1 : 0;
      respSpd = oSpd_en ? respSpd + 1 : 0;
      respCur = oCur_en ? respCur + 1 : 0;
      iPos_done = (respPos == 4);
      iSpd_done = (respSpd == 4) && !spdHang;
      iCur_done = (respCur == 4);
    end
  end

  // Observed events: 1/2/3 = pos/spd/cur enable rising, 4 = cycle done.
  initial begin
    forever begin
      @(negedge iClk);
      if (oPos_en && !prevPos) obsQ.push_back(1);
      if (oSpd_en && !prevSpd) obsQ.push_back(2);
      if (oCur_en && !prevCur) obsQ.push_back(3);
      if (oCycle_done) begin
        obsQ.push_back(4);
        doneCnt++;
      end
      prevPos = oPos_en;
      prevSpd = oSpd_en;
      prevCur = oCur_en;
    end
  end

  task automatic pushExpected();
    if (modelPos == 0) expQ.push_back(1);
    if (modelSpd == 0) expQ.push_back(2);
    expQ.push_back(3);
    expQ.push_back(4);
    modelPos = (modelPos + 1) % POS_DIV;
    modelSpd = (modelSpd + 1) % SPD_DIV;
  endtask

  task automatic pulseTick();
    @(negedge iClk);
    iPwm_tick = 1'b1;
    @(negedge iClk);
    iPwm_tick = 1'b0;
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge iClk);
      if (!oBusy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clearCounters();
    @(negedge iClk);
    iEnable = 1'b0;
    @(negedge iClk);
    iEnable = 1'b1;
    modelPos = 0;
    modelSpd = 0;
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    #12;
    testsRun++;
    if ({oPos_en, oSpd_en, oCur_en, oBusy, oCycle_done, oOverrun, oTimeout} !== 7'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: observed %b expected 0000000",
               {oPos_en, oSpd_en, oCur_en, oBusy, oCycle_done, oOverrun, oTimeout});
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    iEnable = 1'b1;
  endtask

  task automatic test_main();
    int d0, e, o;
    clearCounters();
    d0 = doneCnt;
    for (int k = 0; k < 8; k++) begin
      pushExpected();
      pulseTick();
      repeat (98) @(negedge iClk);
    end
    while (expQ.size() > 0 || obsQ.size() > 0) begin
      e = (expQ.size() > 0) ? expQ.pop_front() : -1;
      o = (obsQ.size() > 0) ? obsQ.pop_front() : -1;
      testsRun++;
      if (o !== e) begin
        testsFailed++;
        $display("[TB] FAIL main_seq: observed event %0d expected %0d", o, e);
      end
    end
    testsRun++;
    if (doneCnt - d0 !== 8) begin
      testsFailed++;
      $display("[TB] FAIL main_done_count: observed %0d expected 8", doneCnt - d0);
    end
  endtask

  task automatic test_timing();
    bit ok, posHeld;
    int e, o;
    clearCounters();
    pushExpected();
    @(negedge iClk);
    iPwm_tick = 1'b1;
    testsRun++;
    if (oPos_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pos_en_before_tick: observed %b expected 0", oPos_en);
    end
    @(negedge iClk);
    iPwm_tick = 1'b0;
    testsRun++;
    if (oPos_en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pos_en_rise: observed %b expected 1", oPos_en);
    end
    posHeld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      if (oPos_en !== 1'b1) posHeld = 1'b0;
    end
    testsRun++;
    if (!posHeld) begin
      testsFailed++;
      $display("[TB] FAIL pos_en_hold: observed dropout expected held 4 cycles");
    end
    @(negedge iClk);
    testsRun++;
    if ({oPos_en, oSpd_en} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL pos_to_spd_handoff: observed %b expected 01", {oPos_en, oSpd_en});
    end
    waitIdle(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL timing_idle: observed busy expected idle within 200 cycles");
    end
    while (expQ.size() > 0 || obsQ.size() > 0) begin
      e = (expQ.size() > 0) ? expQ.pop_front() : -1;
      o = (obsQ.size() > 0) ? obsQ.pop_front() : -1;
      testsRun++;
      if (o !== e) begin
        testsFailed++;
        $display("[TB] FAIL timing_seq: observed event %0d expected %0d", o, e);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int e, o;
    clearCounters();
    testsRun++;
    if (oOverrun !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL overrun_pre: observed %b expected 0", oOverrun);
    end
    pushExpected();
    pulseTick();
    for (int i = 0; i < 50 && !oSpd_en; i++) @(negedge iClk);
    testsRun++;
    if (oSpd_en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL overrun_spd_start: observed %b expected 1", oSpd_en);
    end
    pulseTick();
    testsRun++;
    if (oOverrun !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL overrun_set: observed %b expected 1", oOverrun);
    end
    waitIdle(ok);
    pushExpected();
    pulseTick();
    waitIdle(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL overrun_idle: observed busy expected idle within 200 cycles");
    end
    while (expQ.size() > 0 || obsQ.size() > 0) begin
      e = (expQ.size() > 0) ? expQ.pop_front() : -1;
      o = (obsQ.size() > 0) ? obsQ.pop_front() : -1;
      testsRun++;
      if (o !== e) begin
        testsFailed++;
        $display("[TB] FAIL overrun_seq: observed event %0d expected %0d", o, e);
      end
    end
`ifdef FOC_SCHED_STATS_EN
    testsRun++;
    if (oOverrun_cnt !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL overrun_cnt: observed %0d expected 1", oOverrun_cnt);
    end
`endif
    @(negedge iClk);
    iClr_err = 1'b1;
    @(negedge iClk);
    iClr_err = 1'b0;
    testsRun++;
    if (oOverrun !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL overrun_clear: observed %b expected 0", oOverrun);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int e, o, n;
    clearCounters();
    spdHang = 1'b1;
    testsRun++;
    if (oTimeout !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL timeout_pre: observed %b expected 0", oTimeout);
    end
    pushExpected();
    pulseTick();
    for (int i = 0; i < 50 && !oSpd_en; i++) @(negedge iClk);
    n = 0;
    while (oSpd_en && n < 100) begin
      n++;
      @(negedge iClk);
    end
    testsRun++;
    if (n !== TIMEOUT) begin
      testsFailed++;
      $display("[TB] FAIL timeout_len: observed %0d cycles expected %0d", n, TIMEOUT);
    end
    testsRun++;
    if ({oTimeout, oCur_en} !== 2'b11) begin
      testsFailed++;
      $display("[TB] FAIL timeout_flag_cur: observed %b expected 11", {oTimeout, oCur_en});
    end
    waitIdle(ok);
    spdHang = 1'b0;
    while (expQ.size() > 0 || obsQ.size() > 0) begin
      e = (expQ.size() > 0) ? expQ.pop_front() : -1;
      o = (obsQ.size() > 0) ? obsQ.pop_front() : -1;
      testsRun++;
      if (o !== e) begin
        testsFailed++;
        $display("[TB] FAIL timeout_seq: observed event %0d expected %0d", o, e);
      end
    end
    @(negedge iClk);
    iClr_err = 1'b1;
    @(negedge iClk);
    iClr_err = 1'b0;
    testsRun++;
    if (oTimeout !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL timeout_clear: observed %b expected 0", oTimeout);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int e, o;
    clearCounters();
    expQ.push_back(1);
    expQ.push_back(2);
    expQ.push_back(3);
    pulseTick();
    for (int i = 0; i < 50 && !oCur_en; i++) @(negedge iClk);
    testsRun++;
    if (oCur_en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL enable_cur_start: observed %b expected 1", oCur_en);
    end
    @(negedge iClk);
    iEnable = 1'b0;
    @(negedge iClk);
    testsRun++;
    if ({oPos_en, oSpd_en, oCur_en, oBusy, oCycle_done} !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL enable_drop_outputs: observed %b expected 00000",
               {oPos_en, oSpd_en, oCur_en, oBusy, oCycle_done});
    end
    repeat (5) @(negedge iClk);
    iEnable = 1'b1;
    modelPos = 0;
    modelSpd = 0;
    pushExpected();
    pulseTick();
    waitIdle(ok);
    while (expQ.size() > 0 || obsQ.size() > 0) begin
      e = (expQ.size() > 0) ? expQ.pop_front() : -1;
      o = (obsQ.size() > 0) ? obsQ.pop_front() : -1;
      testsRun++;
      if (o !== e) begin
        testsFailed++;
        $display("[TB] FAIL enable_seq: observed event %0d expected %0d", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e, o;
    clearCounters();
    expQ.push_back(1);
    pulseTick();
    @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    testsRun++;
    if ({oPos_en, oSpd_en, oCur_en, oBusy, oCycle_done, oOverrun, oTimeout} !== 7'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_outputs: observed %b expected 0000000",
               {oPos_en, oSpd_en, oCur_en, oBusy, oCycle_done, oOverrun, oTimeout});
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    modelPos = 0;
    modelSpd = 0;
    pushExpected();
    pulseTick();
    testsRun++;
    if (oPos_en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_pos_start: observed %b expected 1", oPos_en);
    end
    waitIdle(ok);
    while (expQ.size() > 0 || obsQ.size() > 0) begin
      e = (expQ.size() > 0) ? expQ.pop_front() : -1;
      o = (obsQ.size() > 0) ? obsQ.pop_front() : -1;
      testsRun++;
      if (o !== e) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid_seq: observed event %0d expected %0d", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_timing();
    test_overrun();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/foc_loop_scheduler.md
Name: foc_loop_scheduler

Overview:
- Sequences the cascaded FOC control loops once per PWM period: position PI, then speed PI, then current PI.
- Each loop is started by a rising edge on its calculation-enable input and reports completion with its done flag.
- Position and speed loops run at integer sub-rates of the PWM tick; the current loop runs every tick.
- Sits between the PWM timer and the PI loop instances, and flags overruns and hung loops.

Parameters:
- POS_DIV, 16: position loop runs on 1 of every POS_DIV accepted ticks (range 1..256).
- SPD_DIV, 4: speed loop runs on 1 of every SPD_DIV accepted ticks (range 1..256).
- TIMEOUT, 255: max iClk cycles a stage may wait for its done (range 2..65535).

Ports:
- iClk  in  1  system clock
- iRst_n  in  1  asynchronous active-low reset
- iPwm_tick  in  1  single-cycle pulse at PWM period start
- iEnable  in  1  level; scheduler runs while high
- iClr_err  in  1  single-cycle pulse; clears sticky error flags
- oPos_en  out  1  position loop calculation enable
- iPos_done  in  1  position loop done
- oSpd_en  out  1  speed loop calculation enable
- iSpd_done  in  1  speed loop done
- oCur_en  out  1  current loop calculation enable
- iCur_done  in  1  current loop done
- oBusy  out  1  high while not in IDLE
- oCycle_done  out  1  one-cycle pulse when a sequence completes
- oOverrun  out  1  sticky; tick arrived while busy
- oTimeout  out  1  sticky; a stage hit TIMEOUT

Behaviour:
- Reset (async, iRst_n low): all outputs 0, state IDLE, divider counters 0, stage timer 0.
- States: IDLE, POS_RUN, SPD_RUN, CUR_RUN, DONE; all outputs registered.
- IDLE:
  - On iPwm_tick with iEnable high, go to POS_RUN if pos_cnt==0, else SPD_RUN if spd_cnt==0, else CUR_RUN.
  - Entering a RUN state asserts its en on the next cycle, i.e. tick at cycle T gives en high at T+1.
- Divider counters:
  - pos_cnt and spd_cnt increment on each accepted tick and wrap DIV-1 -> 0.
  - With DIV=1 the stage runs on every tick.
- RUN states:
  - Hold own en high for the whole stage; done is sampled only while en is high.
  - On done=1: deassert en, start the next scheduled stage on the same edge (next en high at D+1). Order is POS -> SPD (if scheduled) -> CUR -> DONE.
- Timeout:
  - The stage timer resets on stage entry.
  - If it reaches TIMEOUT without done: set oTimeout, deassert en, advance as if done. The downstream loop uses its previous output.
- DONE: one cycle; pulse oCycle_done; return to IDLE. Every en is therefore low for at least 2 cycles between consecutive runs, which guarantees a fresh rising edge.
- Overrun:
  - iPwm_tick while state is not IDLE sets oOverrun.
  - The tick is dropped and the counters do not advance.
  - A tick in the DONE cycle is also dropped.
- iEnable low: next cycle forces IDLE, all en low, counters cleared to 0, no oCycle_done. Sticky flags are kept.
- iClr_err clears both sticky flags; if a set event occurs in the same cycle, set wins.
- A done asserted on a stage whose en is low is ignored.

Optional Feature:
- Macro: FOC_SCHED_STATS_EN.
- Defined: adds output oOverrun_cnt [15:0], a saturating count of dropped ticks (sticks at 16'hFFFF). Cleared by reset and iClr_err; an increment in the clear cycle yields 1.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package foc_sched_pkg:
  - state encoding constants (IDLE=0, POS_RUN=1, SPD_RUN=2, CUR_RUN=3, DONE=4; 3-bit)
  - divider counter width (8) and stage timer width (16)
- Sub-module foc_tick_divider:
  - parameter DIV; inputs iClk, iRst_n, iClr, iAdv; output oSlot (cnt==0)
  - Instantiated twice, for position and speed.

Test Plan:
- POS_DIV=4, SPD_DIV=2, loops respond with done 3 cycles after en rises, 8 ticks 100 cycles apart -> position runs on ticks 0 and 4, speed on 0/2/4/6, current on all 8; 8 oCycle_done pulses; order POS -> SPD -> CUR each time.
- Tick at cycle 10, all stages scheduled -> oPos_en high at 11; iPos_done at 14 -> oPos_en low and oSpd_en high at 15.
- Second tick while oSpd_en is high -> oOverrun=1, the cycle completes normally, and the next tick uses unchanged counters. With FOC_SCHED_STATS_EN defined, oOverrun_cnt=1.
- TIMEOUT=20, iSpd_done never asserted -> oSpd_en drops 20 cycles after rising, oTimeout=1, oCur_en rises the same edge; iClr_err clears oTimeout.
- iEnable dropped during CUR_RUN -> all en 0 next cycle, oBusy 0, no oCycle_done; after re-enable the first tick runs all three stages (counters back at 0).
- Reset asserted mid POS_RUN -> all outputs 0 immediately; after release the first tick starts POS_RUN.
